local_pps_gen: RTL and testbench
================================

# local_pps_gen

Generates the local 1PPS from the disciplined system clock and closes the loop with the phase measurement block. It counts CLK_SYS cycles to produce a periodic pulse and emits single-cycle edge flags, including Flag_Local_negedge, which stops the phase counter. It accepts signed phase corrections through a valid/ready handshake and applies each one by lengthening or shortening exactly one PPS period.

## Interface
- CLK_FREQ, 10_000_000: nominal CLK_SYS cycles per second.
- PULSE_WIDTH, 1_000_000: Local_PPS high time in cycles; must satisfy 1 ≤ PULSE_WIDTH < CLK_FREQ − MAX_CORR.
- MAX_CORR, 100_000: saturation magnitude for a correction, in cycles.
- MAX_STEP, 1_000: per-period slew limit; used only with LOCAL_PPS_SLEW_LIMIT_EN.
- PHASE_W, 24: correction width.
- CLK_SYS  in  1  system clock; sole clock.
- CLK_RST  in  1  reset; synchronous, active-high.
- Enable  in  1  run/stop for pulse generation.
- Phase_Corr  in  PHASE_W  signed two's-complement correction; positive means delay the next edge.
- Phase_Corr_Valid  in  1  correction offered.
- Phase_Corr_Ready  out  1  correction can be accepted.
- Local_PPS  out  1  registered local pulse.
- Flag_Local_posedge  out  1  one-cycle pulse on the first high cycle of Local_PPS.
- Flag_Local_negedge  out  1  one-cycle pulse on the first low cycle after a high phase.
- Period_Wrap  out  1  one-cycle pulse when the counter reaches terminal count.

## Operation
- States:
  - IDLE: counter held at 0, Local_PPS low.
  - RUN: counting.
- Transitions:
  - IDLE → RUN when Enable is sampled high.
  - RUN → IDLE when Enable is sampled low, at any counter value.
- Counter `cnt` is 32-bit unsigned. In RUN it increments each cycle. At `cnt == term` it wraps to 0 and Period_Wrap pulses.
- `term` is latched at every wrap and on entry to RUN. Nominal value is CLK_FREQ−1. When a correction is pending, `term` is CLK_FREQ−1 + applied correction (signed add, computed in 33-bit, result always ≥ PULSE_WIDTH by the parameter rule).
- Local_PPS is high while `cnt < PULSE_WIDTH` in RUN. Otherwise it is low.
- Correction handshake:
  - A transfer occurs on a cycle where Valid && Ready are both high.
  - The value is saturated to ±MAX_CORR and stored in `pending`, with `pend_v` set.
  - Phase_Corr_Ready = !pend_v.
  - At the next wrap (or RUN entry), `pending` is consumed and `pend_v` clears.
- A transfer accepted in the same cycle as a wrap is not used for that wrap; it applies at the following wrap.
- Valid without Ready: Phase_Corr is ignored; the producer holds it.
- Leaving RUN mid-pulse: Local_PPS falls and Flag_Local_negedge pulses, so the downstream measurement always terminates. `pending` is retained.

## Timing
- Reset values (CLK_RST high at a CLK_SYS edge):
  - State IDLE, `cnt` = 0, `term` = CLK_FREQ−1, `pending` = 0, `pend_v` = 0.
  - Local_PPS, both flags and Period_Wrap = 0.
  - Phase_Corr_Ready = 1.
- Reset asserted mid-pulse forces Local_PPS low with no negedge flag.
- Start-up: Enable sampled high at edge N → Local_PPS and Flag_Local_posedge high after edge N+1.
- Pulse length: exactly PULSE_WIDTH cycles high. Flag_Local_negedge is high in the first low cycle.
- Flag spacing: consecutive Flag_Local_posedge are term+1 cycles apart.
- Handshake latency: Ready returns high the cycle after the wrap that consumes `pending`.
- Saturation: Phase_Corr = 0x7FFFFF with MAX_CORR = 100_000 gives +100_000. 0x800000 gives −100_000.

## Configuration
- LOCAL_PPS_SLEW_LIMIT_EN:
  - Defined: each wrap applies at most ±MAX_STEP and subtracts the applied amount from `pending`. `pend_v` clears only when `pending` reaches 0, so Ready stays low across multiple periods.
  - Undefined: the full saturated correction is applied in one period; MAX_STEP is unused.

## Structure
- Shared package gpsdo_pkg holds:
  - PHASE_W default, CLK_FREQ default.
  - State enum (IDLE, RUN).
  - Signed correction typedef.
- Sub-module pps_corr_sat: combinational saturation to ±limit. It is instantiated for MAX_CORR and, with the macro defined, for MAX_STEP.

## Test plan
- Test parameters: CLK_FREQ=100, PULSE_WIDTH=10, MAX_CORR=20, MAX_STEP=5.
- Reset then Enable=1 → posedge flag 2 edges after Enable. Local_PPS high for 10 cycles, then negedge flag. Posedge flags every 100 cycles.
- Correction +7 accepted mid-period → next period 107 cycles, then 100. Ready low from the cycle after acceptance until the cycle after the wrap.
- Correction −50 → saturated, period 80. Correction +3 offered while pend_v=1 → held until Ready, then period 103.
- Correction accepted on the Period_Wrap cycle → current period stays 100, the following period is adjusted.
- Enable dropped at cnt=4 → Local_PPS low next cycle, negedge flag pulses. Re-enable restarts at cnt=0.
- With LOCAL_PPS_SLEW_LIMIT_EN, correction +12 → periods 105, 105, 102, then 100. Ready high only after the third wrap.

Source files
------------

// File: rtl/gpsdo_pkg.sv
// Shared definitions for the GPSDO local timing blocks: default widths/rates,
// the pulse generator run state and the signed phase-correction type.
package gpsdo_pkg;

  localparam int unsigned PHASE_W_DEF  = 24;
  localparam int unsigned CLK_FREQ_DEF = 10_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pps_state_e;

  typedef logic signed [PHASE_W_DEF-1:0] corr_t;

endpackage

// File: rtl/pps_corr_sat.sv
// Combinational clamp of a signed correction to the symmetric range +/-LIMIT.
module pps_corr_sat #(
  parameter int unsigned W     = 24,
  parameter int unsigned LIMIT = 100_000
) (
  input  logic signed [W-1:0] corr_i,
  output logic signed [W-1:0] corr_o
);

  localparam logic signed [W-1:0] PosLim = W'(LIMIT);
  localparam logic signed [W-1:0] NegLim = -PosLim;

  always_comb begin
    corr_o = corr_i;
    if (corr_i > PosLim) begin
      corr_o = PosLim;
    end else if (corr_i < NegLim) begin
      corr_o = NegLim;
    end
  end

endmodule

// File: rtl/local_pps_gen.sv
// Local 1PPS generator with edge flags and a valid/ready phase-correction input.
// Define LOCAL_PPS_SLEW_LIMIT_EN to spread a correction over periods, MAX_STEP per wrap.
module local_pps_gen
  import gpsdo_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = CLK_FREQ_DEF,
  parameter int unsigned PULSE_WIDTH = 1_000_000,
  parameter int unsigned MAX_CORR    = 100_000,
  parameter int unsigned MAX_STEP    = 1_000,
  parameter int unsigned PHASE_W     = PHASE_W_DEF
) (
  input  logic                      CLK_SYS,
  input  logic                      CLK_RST,
  input  logic                      Enable,
  input  logic signed [PHASE_W-1:0] Phase_Corr,
  input  logic                      Phase_Corr_Valid,
  output logic                      Phase_Corr_Ready,
  output logic                      Local_PPS,
  output logic                      Flag_Local_posedge,
  output logic                      Flag_Local_negedge,
  output logic                      Period_Wrap
);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH + MAX_CORR >= CLK_FREQ || MAX_STEP < 1 || PHASE_W > 32)
  begin : g_param_check
    $error("local_pps_gen: invalid parameter set");
  end

  localparam logic [31:0] NomTerm = 32'(CLK_FREQ - 1);

  pps_state_e                state_q, state_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [31:0]               term_q, term_d;
  logic signed [PHASE_W-1:0] pending_q, pending_d;
  logic                      pend_v_q, pend_v_d;
  logic                      pps_q, pps_d;
  logic                      pos_q, neg_q;
  logic signed [PHASE_W-1:0] corr_sat, apply;
  logic [31:0]               apply_ext;
  logic                      running, wrap, load, xfer;

  pps_corr_sat #(.W(PHASE_W), .LIMIT(MAX_CORR)) u_sat_corr (
    .corr_i (Phase_Corr),
    .corr_o (corr_sat)
  );

`ifdef LOCAL_PPS_SLEW_LIMIT_EN
  pps_corr_sat #(.W(PHASE_W), .LIMIT(MAX_STEP)) u_sat_step (
    .corr_i (pending_q),
    .corr_o (apply)
  );
`else
  assign apply = pending_q;
`endif

  // Sign-extended modulo-2^32 add equals the 33-bit signed sum, which is never negative.
  assign apply_ext = {{(32-PHASE_W){apply[PHASE_W-1]}}, apply};

  assign running = (state_q == RUN) && Enable;
  assign wrap    = running && (cnt_q == term_q);
  assign load    = wrap || ((state_q == IDLE) && Enable);
  assign xfer    = Phase_Corr_Valid && !pend_v_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    term_d    = term_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    pps_d     = running && (cnt_q < 32'(PULSE_WIDTH));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Enable) state_d = RUN;
      end
      RUN: begin
        if (!Enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      term_d = NomTerm;
      if (pend_v_q) begin
        term_d = NomTerm + apply_ext;
`ifdef LOCAL_PPS_SLEW_LIMIT_EN
        pending_d = pending_q - apply;
        pend_v_d  = (pending_q != apply);
`else
        pending_d = '0;
        pend_v_d  = 1'b0;
`endif
      end
    end

    // A transfer needs !pend_v, a consume needs pend_v, so they never collide.
    if (xfer) begin
      pending_d = corr_sat;
      pend_v_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      term_q    <= NomTerm;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      pps_q     <= 1'b0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      term_q    <= term_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      pps_q     <= pps_d;
      pos_q     <= pps_d && !pps_q;
      neg_q     <= pps_q && !pps_d;
    end
  end

  assign Local_PPS          = pps_q;
  assign Flag_Local_posedge = pos_q;
  assign Flag_Local_negedge = neg_q;
  assign Period_Wrap        = wrap;
  assign Phase_Corr_Ready   = !pend_v_q;

endmodule

// File: tb/tb_local_pps_gen.sv
// Directed, table-driven bench for local_pps_gen with small test parameters.
module tb_local_pps_gen;
  import gpsdo_pkg::*;

  localparam int unsigned CF = 100;
  localparam int unsigned PW = 10;
  localparam int unsigned MC = 20;
  localparam int unsigned MS = 5;

  typedef struct {
    corr_t corr;
    int    expPeriod;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  enable = 1'b0;
  logic  corrValid = 1'b0;
  corr_t corr = '0;
  logic  ready, pps, posFlag, negFlag, wrap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  local_pps_gen #(
    .CLK_FREQ    (CF),
    .PULSE_WIDTH (PW),
    .MAX_CORR    (MC),
    .MAX_STEP    (MS),
    .PHASE_W     (PHASE_W_DEF)
  ) dut (
    .CLK_SYS            (clk),
    .CLK_RST            (rst),
    .Enable             (enable),
    .Phase_Corr         (corr),
    .Phase_Corr_Valid   (corrValid),
    .Phase_Corr_Ready   (ready),
    .Local_PPS          (pps),
    .Flag_Local_posedge (posFlag),
    .Flag_Local_negedge (negFlag),
    .Period_Wrap        (wrap)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitPos();
    int n = 0;
    while (!posFlag && n < 300) begin
      tick();
      n++;
    end
    checkOutput("align_posedge", int'(posFlag), 1);
  endtask

  task automatic waitWrap();
    int n = 0;
    while (!wrap && n < 300) begin
      tick();
      n++;
    end
    checkOutput("find_wrap", int'(wrap), 1);
  endtask

  task automatic nextPeriod(output int p);
    p = 0;
    do begin
      tick();
      p++;
    end while (!posFlag && p < 300);
  endtask

  task automatic applyStimulus(input vec_t v);
    int p;
    waitPos();
    repeat (20) tick();
    checkOutput("ready_before_offer", int'(ready), 1);
    corr = v.corr;
    corrValid = 1'b1;
    tick();
    corrValid = 1'b0;
    checkOutput("ready_after_accept", int'(ready), 0);
    waitPos();
    nextPeriod(p);
    checkOutput("corrected_period", p, v.expPeriod);
    nextPeriod(p);
    checkOutput("period_after_corr", p, 100);
  endtask

  initial begin
    vec_t vecs[7];
    int p;
    int hiCount;

    vecs[0] = '{corr: 24'sd7,       expPeriod: 107};
    vecs[1] = '{corr: -24'sd50,     expPeriod: 80};
    vecs[2] = '{corr: 24'sh7FFFFF,  expPeriod: 120};
    vecs[3] = '{corr: 24'sh800000,  expPeriod: 80};
    vecs[4] = '{corr: -24'sd20,     expPeriod: 80};
    vecs[5] = '{corr: 24'sd21,      expPeriod: 120};
    vecs[6] = '{corr: 24'sd0,       expPeriod: 100};

    // Reset state
    tick();
    tick();
    checkOutput("reset_pps", int'(pps), 0);
    checkOutput("reset_posflag", int'(posFlag), 0);
    checkOutput("reset_negflag", int'(negFlag), 0);
    checkOutput("reset_wrap", int'(wrap), 0);
    checkOutput("reset_ready", int'(ready), 1);

    // Start-up: Enable sampled at edge N, pulse visible after edge N+1
    rst = 1'b0;
    enable = 1'b1;
    tick();
    checkOutput("startup_pps_n", int'(pps), 0);
    tick();
    checkOutput("startup_pps_n1", int'(pps), 1);
    checkOutput("startup_posflag", int'(posFlag), 1);
    hiCount = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (pps) hiCount++;
    end
    tick();
    checkOutput("pulse_width", hiCount, 10);
    checkOutput("pps_low_after", int'(pps), 0);
    checkOutput("negflag_first_low", int'(negFlag), 1);
    tick();
    checkOutput("negflag_one_cycle", int'(negFlag), 0);
    waitPos();
    nextPeriod(p);
    checkOutput("nominal_period", p, 100);

`ifndef LOCAL_PPS_SLEW_LIMIT_EN
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Ready stays low through the consuming wrap and returns the cycle after
    waitPos();
    repeat (20) tick();
    corr = 24'sd7;
    corrValid = 1'b1;
    tick();
    corrValid = 1'b0;
    waitWrap();
    checkOutput("ready_in_wrap_cycle", int'(ready), 0);
    tick();
    checkOutput("ready_after_wrap", int'(ready), 1);
    checkOutput("wrap_one_cycle", int'(wrap), 0);
    tick();
    checkOutput("posflag_after_wrap", int'(posFlag), 1);
    nextPeriod(p);
    checkOutput("hs_period_107", p, 107);
    nextPeriod(p);
    checkOutput("hs_period_100", p, 100);

    // Second offer held while a correction is pending
    repeat (20) tick();
    corr = -24'sd50;
    corrValid = 1'b1;
    tick();
    corr = 24'sd3;
    tick();
    checkOutput("held_ready_low", int'(ready), 0);
    p = 0;
    while (!ready && p < 300) begin
      tick();
      p++;
    end
    checkOutput("held_ready_return", int'(ready), 1);
    tick();
    corrValid = 1'b0;
    checkOutput("held_accepted", int'(ready), 0);
    checkOutput("held_posflag", int'(posFlag), 1);
    nextPeriod(p);
    checkOutput("held_period_80", p, 80);
    nextPeriod(p);
    checkOutput("held_period_103", p, 103);
    nextPeriod(p);
    checkOutput("held_period_100", p, 100);

    // Transfer on the wrap cycle applies one period later
    waitWrap();
    corr = 24'sd7;
    corrValid = 1'b1;
    tick();
    corrValid = 1'b0;
    checkOutput("wrapacc_ready_low", int'(ready), 0);
    tick();
    checkOutput("wrapacc_posflag", int'(posFlag), 1);
    nextPeriod(p);
    checkOutput("wrapacc_period_100", p, 100);
    nextPeriod(p);
    checkOutput("wrapacc_period_107", p, 107);
    nextPeriod(p);
    checkOutput("wrapacc_period_after", p, 100);
`else
    // Slew-limited: +12 spread as 5, 5, 2
    waitPos();
    repeat (20) tick();
    corr = 24'sd12;
    corrValid = 1'b1;
    tick();
    corrValid = 1'b0;
    waitPos();
    nextPeriod(p);
    checkOutput("slew_period_1", p, 105);
    checkOutput("slew_ready_1", int'(ready), 0);
    nextPeriod(p);
    checkOutput("slew_period_2", p, 105);
    checkOutput("slew_ready_3rd_wrap", int'(ready), 1);
    nextPeriod(p);
    checkOutput("slew_period_3", p, 102);
    nextPeriod(p);
    checkOutput("slew_period_4", p, 100);
`endif

    // Enable dropped at cnt=4 with a correction pending; re-entry consumes it
    waitPos();
    corr = 24'sd3;
    corrValid = 1'b1;
    tick();
    corrValid = 1'b0;
    tick();
    tick();
    checkOutput("drop_pps_before", int'(pps), 1);
    enable = 1'b0;
    tick();
    checkOutput("drop_pps_low", int'(pps), 0);
    checkOutput("drop_negflag", int'(negFlag), 1);
    checkOutput("drop_pending_kept", int'(ready), 0);
    tick();
    checkOutput("drop_negflag_clear", int'(negFlag), 0);
    checkOutput("idle_pps", int'(pps), 0);
    enable = 1'b1;
    tick();
    checkOutput("reenable_pps_n", int'(pps), 0);
    checkOutput("reenable_consumed", int'(ready), 1);
    tick();
    checkOutput("reenable_posflag", int'(posFlag), 1);
    nextPeriod(p);
    checkOutput("reenable_period_103", p, 103);
    nextPeriod(p);
    checkOutput("reenable_period_100", p, 100);

    // Reset mid-pulse: pulse drops without a negedge flag
    tick();
    tick();
    checkOutput("rstmid_pps_high", int'(pps), 1);
    rst = 1'b1;
    tick();
    checkOutput("rstmid_pps_low", int'(pps), 0);
    checkOutput("rstmid_no_negflag", int'(negFlag), 0);
    checkOutput("rstmid_ready", int'(ready), 1);
    rst = 1'b0;
    enable = 1'b0;
    tick();
    checkOutput("rstmid_still_no_negflag", int'(negFlag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
